// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the register-bank write-back controller
package wb_pkg;

    localparam int NREGS = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter holding the last-grant state
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit SRC_ALU = ALU, bit SRC_MEM = load unit
//   gnt[1:0]   : combinational one-hot grant (all zero when nothing requests)
module rr_arb2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e last_grant_q;
    wb_src_e last_grant_d;

    // A lone requester always wins; on a tie the source that did not win last goes.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant_q == SRC_MEM) ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt[1]) begin
            last_grant_d = SRC_MEM;
        end else if (gnt[0]) begin
            last_grant_d = SRC_ALU;
        end
    end

    // Reset to MEM so the ALU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SRC_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - write-back arbiter and pending-write scoreboard for the register bank
//   clk, rst_n                     : clock, asynchronous active-low reset
//   issue_valid/issue_rd/issue_ready : decoder issue of an instruction writing issue_rd
//   rs1, rs2 / rs1_busy, rs2_busy  : decode-stage sources and their hazard flags
//   alu_valid/alu_rd/alu_data/alu_ready : ALU write-back request and grant
//   mem_valid/mem_rd/mem_data/mem_ready : load write-back request and grant
//   wb_write/wb_rd/wb_data         : registered drive of the bank write port
//   rs1_fwd, rs2_fwd               : present only with WB_FORWARD_EN defined
module regfile_wb_ctrl
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = wb_pkg::NREGS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  reg_idx_t        issue_rd,
    output logic            issue_ready,
    input  reg_idx_t        rs1,
    input  reg_idx_t        rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            alu_valid,
    input  reg_idx_t        alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  reg_idx_t        mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            wb_write,
    output reg_idx_t        wb_rd,
    output logic [XLEN-1:0] wb_data
`ifdef WB_FORWARD_EN
    ,
    output logic            rs1_fwd,
    output logic            rs2_fwd
`endif
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wb_write_q;
    reg_idx_t         wb_rd_q;
    logic [XLEN-1:0]  wb_data_q;

    logic [1:0]       gnt;
    logic             grant_any;
    reg_idx_t         grant_rd;
    logic [XLEN-1:0]  grant_data;
    logic             issue_set;

    // Register 0 is hardwired, so it never blocks issue and never reports a hazard.
    assign issue_ready = !busy_q[issue_rd] || (issue_rd == '0);
    assign issue_set   = issue_valid && issue_ready && (issue_rd != '0);

`ifdef WB_FORWARD_EN
    assign rs1_fwd  = wb_write_q && (wb_rd_q == rs1) && (rs1 != '0);
    assign rs2_fwd  = wb_write_q && (wb_rd_q == rs2) && (rs2 != '0);
    assign rs1_busy = busy_q[rs1] && (rs1 != '0) && !rs1_fwd;
    assign rs2_busy = busy_q[rs2] && (rs2 != '0) && !rs2_fwd;
`else
    assign rs1_busy = busy_q[rs1] && (rs1 != '0);
    assign rs2_busy = busy_q[rs2] && (rs2 != '0);
`endif

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({mem_valid, alu_valid}),
        .gnt   (gnt)
    );

    assign alu_ready  = gnt[SRC_ALU];
    assign mem_ready  = gnt[SRC_MEM];
    assign grant_any  = |gnt;
    assign grant_rd   = gnt[SRC_MEM] ? mem_rd   : alu_rd;
    assign grant_data = gnt[SRC_MEM] ? mem_data : alu_data;

    // The clear retires the write the bank took on the previous negedge. A set of
    // the same index can only coincide with a no-op clear (register not busy), and
    // then the new pending write must win, so the set is applied last.
    always_comb begin
        busy_d = busy_q;
        if (wb_write_q) begin
            busy_d[wb_rd_q] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            wb_write_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            busy_q     <= busy_d;
            wb_write_q <= grant_any && (grant_rd != '0);
            if (grant_any) begin
                wb_rd_q   <= grant_rd;
                wb_data_q <= grant_data;
            end
        end
    end

    assign wb_write = wb_write_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 32×32 integer register bank. Shares the bank's single write port between the ALU and the load/memory unit using round-robin arbitration. Keeps a 32-entry scoreboard of destination registers with writes still pending, so the decoder can stall on RAW and WAW hazards. Sits between the execute/memory stages and the register bank write inputs (`write`, `rd`, `write_data`).

## Interface
Parameters:
- `XLEN`, 32, data width
- `NREGS`, 32, register count; index width is log2(NREGS) = 5

Ports:
- `clk`  in  1  clock, posedge logic
- `rst_n`  in  1  asynchronous reset, active low
- `issue_valid`  in  1  decoder issues an instruction that writes `issue_rd`
- `issue_rd`  in  5  destination of the issuing instruction
- `issue_ready`  out  1  issue accepted this cycle
- `rs1`, `rs2`  in  5 each  source registers of the instruction in decode
- `rs1_busy`, `rs2_busy`  out  1 each  source has a pending write; decoder stalls
- `alu_valid`, `alu_rd`, `alu_data`  in  1/5/XLEN  ALU write-back request
- `alu_ready`  out  1  ALU request granted
- `mem_valid`, `mem_rd`, `mem_data`  in  1/5/XLEN  load write-back request
- `mem_ready`  out  1  load request granted
- `wb_write`, `wb_rd`, `wb_data`  out  1/5/XLEN  connect to the bank's `write`, `rd`, `write_data`

## Operation
- Scoreboard `busy[31:0]` is a register with one bit per architectural register.
- Issue:
  - `issue_ready = !busy[issue_rd] || issue_rd == 0`. This is a combinational WAW stall.
  - On `issue_valid && issue_ready && issue_rd != 0`, set `busy[issue_rd]`.
- Hazard outputs: `rsN_busy = busy[rsN] && rsN != 0`. They are combinational.
- Arbitration:
  - `alu_ready` and `mem_ready` are combinational and never both 1.
  - If only one source is valid, that source is granted.
  - If both are valid, grant the source not recorded in `last_grant`.
  - `last_grant` updates on every grant. Reset value is MEM, so the ALU wins the first tie.
- Output stage: a granted request is registered into `wb_write`, `wb_rd`, `wb_data`.
  - `wb_write = 1` only if the granted rd is nonzero.
  - With no grant, `wb_write = 0`; `wb_rd` and `wb_data` hold their previous values.
- Clear: when `wb_write = 1`, clear `busy[wb_rd]` at the next posedge. At that point the bank has written on the intervening negedge.
- Boundary cases:
  - Set and clear of the same register at the same posedge cannot occur. An issue to a busy rd is stalled, and `issue_ready` stays 0 until the clear has taken effect.
  - Set and clear of different registers in the same cycle are independent.
  - A write-back to a register that is not busy is written normally; the clear is a no-op.
  - Both sources targeting the same rd are serialized by the arbiter, in grant order.
  - An rd of 0 is accepted, produces no write, and never sets busy.

## Timing
- Reset (`rst_n` low, asynchronous, also mid-operation): all `busy` = 0, `wb_write` = 0, `wb_rd` = 0, `wb_data` = 0, `last_grant` = MEM.
  - Combinational outputs follow from that state: `issue_ready` = 1, `rsN_busy` = 0.
  - `alu_ready` and `mem_ready` follow the valids.
  - Pending writes are discarded.
- Grant at posedge k: `wb_write` is high during cycle k..k+1, and the bank captures at the negedge inside that cycle.
- `busy` clears at posedge k+1. `rsN_busy` drops in cycle k+1.
- Issue-to-busy latency: busy is visible the cycle after issue acceptance.
- Throughput: one write-back per cycle. The loser of a tie waits at most one cycle.

## Configuration
- `WB_FORWARD_EN` defined:
  - Adds outputs `rs1_fwd` (out 1) and `rs2_fwd` (out 1).
  - `rsN_fwd = wb_write && wb_rd == rsN && rsN != 0`.
  - When `rsN_fwd` is 1, `rsN_busy` is forced to 0. The consumer takes `wb_data` that cycle, one cycle earlier than without forwarding.
- Not defined: no forward ports. `rsN_busy` is driven purely from `busy`.

## Structure
- Package `wb_pkg`:
  - `typedef logic [4:0] reg_idx_t`
  - `typedef enum logic {SRC_ALU, SRC_MEM} wb_src_e`
  - `localparam NREGS = 32`
- Sub-module `rr_arb2`: two-requester round-robin arbiter with the `last_grant` register. Inputs are `clk`, `rst_n`, `req[1:0]`; output is one-hot `gnt[1:0]`.

## Test plan
- Reset, then issue rd=5 → `busy[5]` = 1 the next cycle. With `rs1` = 5, `rs1_busy` = 1. A second issue to rd=5 sees `issue_ready` = 0.
- ALU write-back rd=5, data 0xDEADBEEF → `alu_ready` = 1 that cycle. Next cycle `wb_write` = 1, `wb_rd` = 5, `wb_data` = 0xDEADBEEF. `rs1_busy` = 0 one cycle later. Bank reads back 0xDEADBEEF.
- ALU (rd=3) and MEM (rd=4) both valid for 3 cycles from reset → grants ALU, MEM, ALU. `wb_rd` sequence is 3, 4, 3.
- Issue rd=0 and write back rd=0 → `busy` stays 0 and `wb_write` = 0.
- Assert `rst_n` low with rd=7 busy and a write-back pending → `busy` = 0 and `wb_write` = 0 immediately, without waiting for a clock.
- With `WB_FORWARD_EN` defined: `rs2` = 9 and `wb_write` = 1, `wb_rd` = 9 → `rs2_fwd` = 1 and `rs2_busy` = 0 in the same cycle.
